// File: rtl/count_ones_c.sv
// Serial population counter: loads a word, then counts its set bits one per cycle.
// Define COUNT_ONES_C_DONE_EN to add a one-cycle 'done' pulse aligned with each new result.
module count_ones_c #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned COUNT_WIDTH = 3
) (
    output logic [COUNT_WIDTH-1:0] bit_count,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   clk,
    input  logic                   reset
`ifdef COUNT_ONES_C_DONE_EN
    ,
    output logic                   done
`endif
);

    localparam int unsigned STEP_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [COUNT_WIDTH-1:0] acc;
    logic [STEP_W-1:0]      step;
    logic [COUNT_WIDTH-1:0] acc_next_c;

    // Running count including the bit currently at the LSB.
    assign acc_next_c = acc + COUNT_WIDTH'(shift_q[0]);

    // Free-running LOAD / SHIFT loop; result published only on the final shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_LOAD;
            shift_q   <= '0;
            acc       <= '0;
            step      <= '0;
            bit_count <= '0;
`ifdef COUNT_ONES_C_DONE_EN
            done      <= 1'b0;
`endif
        end else begin
`ifdef COUNT_ONES_C_DONE_EN
            done <= 1'b0;
`endif
            case (state)
                ST_LOAD: begin
                    shift_q <= data;
                    acc     <= '0;
                    step    <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    acc     <= acc_next_c;
                    shift_q <= shift_q >> 1;
                    step    <= step + STEP_W'(1);
                    if (step == LAST_STEP) begin
                        bit_count <= acc_next_c;
                        state     <= ST_LOAD;
`ifdef COUNT_ONES_C_DONE_EN
                        done      <= 1'b1;
`endif
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_count_ones_c.sv
// Directed bench for count_ones_c (4-bit and 8-bit instances) with a period-based reference model.
module tb_count_ones_c;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] data = 4'h0;
    logic [2:0] bit_count;
    logic       reset8 = 1'b0;
    logic [7:0] data8 = 8'h00;
    logic [3:0] bit_count8;
`ifdef COUNT_ONES_C_DONE_EN
    logic       done4;
    logic       done8;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    count_ones_c #(.DATA_WIDTH(4), .COUNT_WIDTH(3)) dut4 (
        .bit_count(bit_count),
        .data     (data),
        .clk      (clk),
        .reset    (reset)
`ifdef COUNT_ONES_C_DONE_EN
        , .done   (done4)
`endif
    );

    count_ones_c #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut8 (
        .bit_count(bit_count8),
        .data     (data8),
        .clk      (clk),
        .reset    (reset8)
`ifdef COUNT_ONES_C_DONE_EN
        , .done   (done8)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: period of W+1 edges from reset release, sample on phase 0, publish on phase W.
    int k4 = 0, pend4 = 0, exp4 = 0;
    bit expd4 = 1'b0;
    always @(posedge clk) begin
        if (!reset) begin
            k4 <= 0; exp4 <= 0; expd4 <= 1'b0;
        end else begin
            if (k4 % 5 == 0) pend4 <= $countones(data);
            if (k4 % 5 == 4) begin
                exp4 <= pend4; expd4 <= 1'b1;
            end else begin
                expd4 <= 1'b0;
            end
            k4 <= k4 + 1;
        end
    end

    int k8 = 0, pend8 = 0, exp8 = 0;
    bit expd8 = 1'b0;
    always @(posedge clk) begin
        if (!reset8) begin
            k8 <= 0; exp8 <= 0; expd8 <= 1'b0;
        end else begin
            if (k8 % 9 == 0) pend8 <= $countones(data8);
            if (k8 % 9 == 8) begin
                exp8 <= pend8; expd8 <= 1'b1;
            end else begin
                expd8 <= 1'b0;
            end
            k8 <= k8 + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_bc4", 32'(bit_count), 32'(exp4));
        check("model_bc8", 32'(bit_count8), 32'(exp8));
`ifdef COUNT_ONES_C_DONE_EN
        check("model_done4", 32'(done4), 32'(expd4));
        check("model_done8", 32'(done8), 32'(expd8));
`endif
    end

    task automatic lit(input string name, input int exp_bc, input bit exp_done);
        check(name, 32'(bit_count), 32'(exp_bc));
`ifdef COUNT_ONES_C_DONE_EN
        check({name, "_done"}, 32'(done4), 32'(exp_done));
`else
        if (exp_done) begin end
`endif
    endtask

    logic [3:0] words [6] = '{4'ha, 4'h5, 4'hb, 4'h9, 4'h0, 4'hc};
    int         counts[6] = '{2, 2, 3, 2, 0, 2};

    initial begin
        // Reset with all-ones word held
        data = 4'hf;
        repeat (2) @(negedge clk);
        lit("reset_zero", 0, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        lit("hold_before_first", 0, 1'b0);
        @(negedge clk);
        lit("first_all_ones", 4, 1'b1);

        // Word sequence, one per period
        for (int i = 0; i < 6; i++) begin
            data = words[i];
            repeat (4) @(negedge clk);
            lit($sformatf("seq%0d_hold", i), (i == 0) ? 4 : counts[i-1], 1'b0);
            @(negedge clk);
            lit($sformatf("seq%0d", i), counts[i], 1'b1);
        end

        // Data changed right after capture must not matter
        data = 4'hf;
        @(negedge clk);
        data = 4'h0;
        repeat (4) @(negedge clk);
        lit("late_change", 4, 1'b1);
        repeat (5) @(negedge clk);
        lit("after_late_change", 0, 1'b1);

        // Mid-conversion reset abandons the conversion
        data = 4'hb;
        repeat (5) @(negedge clk);
        lit("pre_reset_three", 3, 1'b1);
        data = 4'hf;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        lit("mid_reset_zero", 0, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        lit("post_reset_hold", 0, 1'b0);
        @(negedge clk);
        lit("post_reset_result", 4, 1'b1);

        // 8-bit instance
        data8 = 8'hff;
        @(negedge clk);
        check("w8_reset", 32'(bit_count8), 32'd0);
        reset8 = 1'b1;
        repeat (8) @(negedge clk);
        check("w8_hold", 32'(bit_count8), 32'd0);
        @(negedge clk);
        check("w8_ff", 32'(bit_count8), 32'd8);
        data8 = 8'h81;
        repeat (8) @(negedge clk);
        check("w8_hold2", 32'(bit_count8), 32'd8);
        @(negedge clk);
        check("w8_81", 32'(bit_count8), 32'd2);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/count_ones_c.md
COUNT_ONES_C -- requirements
Module: count_ones_c

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, giving the width of the input word.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 3, giving the width of the result; legal only if 2**COUNT_WIDTH > DATA_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port data, input, DATA_WIDTH bits: the word whose set bits are counted.
REQ-006 The block SHALL have port bit_count, output, COUNT_WIDTH bits, registered: the number of 1 bits in the most recently completed word.
REQ-007 The port order SHALL be bit_count, data, clk, reset.

Function
REQ-008 The block SHALL run a free-running serial conversion loop: one LOAD state followed by DATA_WIDTH SHIFT states, giving a conversion period of DATA_WIDTH+1 cycles.
REQ-009 In LOAD, the block SHALL capture data into an internal shift register and clear the accumulator, then go to SHIFT with a step counter of 0.
REQ-010 In each SHIFT cycle, the block SHALL add the shift register LSB to the accumulator, shift the register right by one, and increment the step counter.
REQ-011 On the last SHIFT cycle (step DATA_WIDTH-1), the block SHALL write accumulator + LSB to bit_count and return to LOAD.
REQ-012 bit_count SHALL change only on the last SHIFT cycle of a conversion, and SHALL hold its value at all other times.
REQ-013 Changes to data after its LOAD capture SHALL NOT affect the conversion in progress; data is sampled exactly once per period.
REQ-014 The accumulator SHALL be COUNT_WIDTH bits wide; an all-ones word SHALL yield DATA_WIDTH exactly, with no wrap.
REQ-015 Latency: the result for data sampled at LOAD edge N SHALL appear on bit_count after edge N+DATA_WIDTH.
REQ-016 Unused state encodings SHALL return to LOAD on the next edge.

Reset
REQ-017 When reset is low at a rising edge of clk, the block SHALL set bit_count=0, accumulator=0, shift register=0, step counter=0 and state=LOAD.
REQ-018 Reset asserted mid-conversion SHALL abandon that conversion with no partial result published.
REQ-019 After reset goes high, the first LOAD SHALL occur at the first edge with reset high, and the first result SHALL appear DATA_WIDTH edges later.
REQ-020 The block SHALL NOT use any asynchronous reset path.

Configuration
REQ-021 The block SHALL honour the macro COUNT_ONES_C_DONE_EN.
REQ-022 With COUNT_ONES_C_DONE_EN defined, the block SHALL have an extra output done, 1 bit, last in the port list.
REQ-023 done SHALL be registered, SHALL be high for exactly the one cycle in which bit_count takes a new result, and SHALL be 0 in and after reset.
REQ-024 Without COUNT_ONES_C_DONE_EN, the done port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 Default parameters, reset low for 1+ edges then high, data=4'hf held -> bit_count=0 during reset, then 4 after the 5th edge with reset high.
REQ-026 Words 4'ha, 4'h5, 4'hb, 4'h9, 4'h0, 4'hc, each held for one full period -> bit_count sequence 2, 2, 3, 2, 0, 2, each updating exactly 5 cycles apart.
REQ-027 data=4'hf at LOAD, changed to 4'h0 on the next cycle -> that conversion reports 4; the following conversion reports 0.
REQ-028 Reset pulsed low for one edge during SHIFT step 2 with bit_count=3 -> bit_count=0 immediately; the next result appears 5 edges after reset is released.
REQ-029 DATA_WIDTH=8, COUNT_WIDTH=4, data=8'hff, then 8'h81 -> bit_count=8, then 2, updating every 9 cycles.
REQ-030 Build with COUNT_ONES_C_DONE_EN -> done is a single-cycle pulse aligned with every bit_count update and low during reset; without the macro, results match the REQ-026 run exactly.
